// File: rtl/vcpu_pkg.sv
// Shared vcpu definitions: default datapath widths and the program loader state encoding.
package vcpu_pkg;

    localparam int VCPU_ADDR_WIDTH = 16;
    localparam int VCPU_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CKSUM,
        RUN,
        ERROR
    } loaderState_t;

endpackage

// File: rtl/vcpu_mem_port_mux.sv
// Single-port memory owner select: the CPU drives memory when it owns the port, otherwise the loader does.
module vcpu_mem_port_mux #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  cpuOwns,
    input  logic                  cpuWe,
    input  logic [ADDR_WIDTH-1:0] cpuAddress,
    input  logic [DATA_WIDTH-1:0] cpuData,
    input  logic                  loaderWe,
    input  logic [ADDR_WIDTH-1:0] loaderAddress,
    input  logic [DATA_WIDTH-1:0] loaderData,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data
);

    assign mem_we      = cpuOwns ? cpuWe      : loaderWe;
    assign mem_address = cpuOwns ? cpuAddress : loaderAddress;
    assign mem_data    = cpuOwns ? cpuData    : loaderData;

endmodule

// File: rtl/vcpu_mem_loader.sv
// Streams a program image into memory while holding the CPU in reset, then hands the port to the CPU.
// Optional trailer checksum verification is enabled by defining VCPU_LOADER_CHECKSUM_EN.
module vcpu_mem_loader
    import vcpu_pkg::*;
#(
    parameter int ADDR_WIDTH = VCPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = VCPU_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  cpu_mem_we,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
    input  logic [DATA_WIDTH-1:0] cpu_mem_data,
    output logic [DATA_WIDTH-1:0] cpu_mem_q,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

`ifdef VCPU_LOADER_CHECKSUM_EN
    localparam loaderState_t POST_LOAD = CKSUM;
`else
    localparam loaderState_t POST_LOAD = RUN;
`endif

    loaderState_t          state;
    loaderState_t          nextState;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  count;
    logic                  cpuResetReg;
    logic                  busyReg;
    logic                  doneReg;
    logic                  startLoad;
    logic                  xfer;
    logic                  loaderWe;

`ifdef VCPU_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] sumNext;
    logic                  errorReg;

    assign sumNext = sum + in_data;
    assign error   = errorReg;
`else
    assign error = 1'b0;
`endif

    assign in_ready  = (state == LOAD) || (state == CKSUM);
    assign loaderWe  = in_valid && (state == LOAD);
    assign cpu_reset = cpuResetReg;
    assign busy      = busyReg;
    assign done      = doneReg;
    assign cpu_mem_q = mem_q;

    // Start is honoured from every resting state, so a running CPU can be reloaded in place.
    always_comb begin
        nextState = state;
        startLoad = 1'b0;
        xfer      = 1'b0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    xfer = 1'b1;
                    if (count == LEN_WIDTH'(1)) begin
                        nextState = POST_LOAD;
                    end
                end
            end
`ifdef VCPU_LOADER_CHECKSUM_EN
            CKSUM: begin
                if (in_valid) begin
                    nextState = (sumNext == '0) ? RUN : ERROR;
                end
            end
`endif
            default: begin
                if (start) begin
                    startLoad = 1'b1;
                    nextState = (load_len == '0) ? POST_LOAD : LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr        <= '0;
            count       <= '0;
            cpuResetReg <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
`ifdef VCPU_LOADER_CHECKSUM_EN
            sum         <= '0;
            errorReg    <= 1'b0;
`endif
        end else begin
            state       <= nextState;
            cpuResetReg <= (nextState == RUN);
            doneReg     <= (nextState == RUN);
            busyReg     <= (nextState == LOAD) || (nextState == CKSUM);
`ifdef VCPU_LOADER_CHECKSUM_EN
            errorReg    <= (nextState == ERROR);
`endif
            if (startLoad) begin
                addr  <= load_base;
                count <= load_len;
`ifdef VCPU_LOADER_CHECKSUM_EN
                sum   <= '0;
`endif
            end else if (xfer) begin
                addr  <= addr + 1'b1;
                count <= count - 1'b1;
`ifdef VCPU_LOADER_CHECKSUM_EN
                sum   <= sumNext;
`endif
            end
        end
    end

    vcpu_mem_port_mux #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) portMux (
        .cpuOwns      (state == RUN),
        .cpuWe        (cpu_mem_we),
        .cpuAddress   (cpu_mem_address),
        .cpuData      (cpu_mem_data),
        .loaderWe     (loaderWe),
        .loaderAddress(addr),
        .loaderData   (in_data),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data     (mem_data)
    );

endmodule

// File: tb/tb_vcpu_mem_loader.sv
// Self-checking bench for vcpu_mem_loader: a loader model tracks expected outputs and memory every cycle.
module tb_vcpu_mem_loader;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 17;
`ifdef VCPU_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [LW-1:0] load_len = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_mem_we = 1'b0;
    logic [AW-1:0] cpu_mem_address = '0;
    logic [DW-1:0] cpu_mem_data = '0;
    logic [DW-1:0] cpu_mem_q;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;
    bit clearReq = 1'b0;
    bit cpuSpam = 1'b0;

    logic [7:0] ram [0:65535];
    logic [7:0] expMem [0:65535];
    logic [7:0] image [$];
    logic [7:0] words [$];

    // Model of the loader in terms of remaining words, run/await/error flags and next address.
    int mRemain = 0;
    int mAddr = 0;
    int mSum = 0;
    bit mRunning = 1'b0;
    bit mAwait = 1'b0;
    bit mErr = 1'b0;

    vcpu_mem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .load_base      (load_base),
        .load_len       (load_len),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .cpu_mem_we     (cpu_mem_we),
        .cpu_mem_address(cpu_mem_address),
        .cpu_mem_data   (cpu_mem_data),
        .cpu_mem_q      (cpu_mem_q),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_q          (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clearReq) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        end else if (mem_we) begin
            ram[mem_address] <= mem_data;
        end
    end
    assign mem_q = ram[mem_address];

    task automatic finishPayload();
        if (CK == 1) mAwait = 1'b1;
        else mRunning = 1'b1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (clearReq) begin
            for (int i = 0; i < 65536; i++) expMem[i] = 8'h00;
        end
        if (!reset) begin
            mRemain = 0; mAddr = 0; mSum = 0;
            mRunning = 1'b0; mAwait = 1'b0; mErr = 1'b0;
        end else if (mRemain > 0) begin
            if (in_valid) begin
                expMem[mAddr] = in_data;
                mAddr = (mAddr + 1) % 65536;
                mSum = (mSum + int'(in_data)) % 256;
                mRemain--;
                if (mRemain == 0) finishPayload();
            end
        end else if (mAwait) begin
            if (in_valid) begin
                mAwait = 1'b0;
                if ((mSum + int'(in_data)) % 256 == 0) mRunning = 1'b1;
                else mErr = 1'b1;
            end
        end else if (start) begin
            mAddr = int'(load_base);
            mRemain = int'(load_len);
            mSum = 0;
            mRunning = 1'b0;
            mErr = 1'b0;
            if (mRemain == 0) finishPayload();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: outputs and memory port must match the model.
    always @(negedge clk) begin
        bit loading;
        bit expBusy;
        bit expWe;
        if (checkEn) begin
            loading = (mRemain > 0);
            expBusy = loading || mAwait;
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("in_ready", 32'(in_ready), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(mRunning));
            checkOutput("cpu_reset", 32'(cpu_reset), 32'(mRunning));
            checkOutput("error", 32'(error), 32'(mErr));
            expWe = mRunning ? cpu_mem_we : (loading && in_valid);
            checkOutput("mem_we", 32'(mem_we), 32'(expWe));
            if (mRunning) begin
                checkOutput("mem_address_cpu", 32'(mem_address), 32'(cpu_mem_address));
                checkOutput("mem_data_cpu", 32'(mem_data), 32'(cpu_mem_data));
            end else begin
                checkOutput("mem_address_ldr", 32'(mem_address), 32'(mAddr));
                if (expWe) checkOutput("mem_data_ldr", 32'(mem_data), 32'(in_data));
            end
            checkOutput("cpu_mem_q", 32'(cpu_mem_q), 32'(ram[mem_address]));
        end
    end

    task automatic clearRams();
        @(posedge clk); #1;
        clearReq = 1'b1;
        @(posedge clk); #1;
        clearReq = 1'b0;
    endtask

    // Start a load and stream q (plus a correct trailer in checksum builds when asked).
    task automatic applyStimulus(input logic [15:0] base, input int len, input bit gaps,
                                 input bit addTrailer, output int busyCnt);
        logic [7:0] q [$];
        int sum;
        int idx;
        int k;
        bit xf;
        q = words;
        sum = 0;
        foreach (q[i]) sum = sum + int'(q[i]);
        if (CK == 1 && addTrailer) q.push_back(8'((256 - (sum % 256)) % 256));
        @(posedge clk); #1;
        start = 1'b1;
        load_base = base;
        load_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        if (cpuSpam) begin
            cpu_mem_we = 1'b1;
            cpu_mem_address = 16'h1234;
            cpu_mem_data = 8'hEE;
        end
        idx = 0;
        k = 0;
        busyCnt = 0;
        while (idx < q.size() && k < 400) begin
            in_valid = gaps ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            in_data = q[idx];
            @(negedge clk);
            if (busy) busyCnt++;
            xf = in_valid && in_ready;
            @(posedge clk); #1;
            if (xf) idx++;
            k++;
        end
        in_valid = 1'b0;
        cpu_mem_we = 1'b0;
        if (idx < q.size()) checkOutput("xfer_budget", 32'(idx), 32'(q.size()));
    endtask

    task automatic checkMemRange(input string name, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(name, 32'(ram[(base + i) % 65536]), 32'(expMem[(base + i) % 65536]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int bc;
        bit xf;
        image = '{8'h50, 8'h11, 8'h01, 8'h22, 8'h52, 8'h50, 8'h05, 8'h10,
                  8'h50, 8'h12, 8'h80, 8'h11, 8'h77, 8'h56, 8'hF9, 8'h31};

        clearReq = 1'b1;
        repeat (2) @(posedge clk);
        #1 clearReq = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 0);
        checkOutput("rst_error", 32'(error), 0);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        checkEn = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;

        $display("[TB] image load, steady valid");
        words = image;
        applyStimulus(16'h0000, 16, 1'b0, 1'b1, bc);
        checkOutput("img_busy_cycles", 32'(bc), 32'(16 + CK));
        @(negedge clk);
        checkOutput("img_done", 32'(done), 1);
        checkOutput("img_cpu_reset", 32'(cpu_reset), 1);
        checkMemRange("img_mem", 0, 16);
        checkOutput("img_mem0", 32'(ram[0]), 32'h50);
        checkOutput("img_mem15", 32'(ram[15]), 32'h31);
        checkOutput("model_mem15", 32'(expMem[15]), 32'h31);
        cpu_mem_address = 16'h0000;
        @(negedge clk);
        checkOutput("cpu_fetch0", 32'(cpu_mem_q), 32'h50);

        $display("[TB] CPU write while running");
        @(posedge clk); #1;
        cpu_mem_we = 1'b1; cpu_mem_address = 16'h0100; cpu_mem_data = 8'h5A;
        @(posedge clk); #1;
        cpu_mem_we = 1'b0;
        @(negedge clk);
        checkOutput("cpu_write", 32'(ram[16'h0100]), 32'h5A);

        $display("[TB] image load, backpressure gaps");
        clearRams();
        applyStimulus(16'h0000, 16, 1'b1, 1'b1, bc);
        checkOutput("gap_busy_cycles", 32'(bc), 32'(32 + CK));
        @(negedge clk);
        checkOutput("gap_done", 32'(done), 1);
        checkMemRange("gap_mem", 0, 16);
        checkOutput("gap_mem5", 32'(ram[5]), 32'h50);

        $display("[TB] address wrap");
        words = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(16'hFFFE, 4, 1'b0, 1'b1, bc);
        @(negedge clk);
        checkOutput("wrap_done", 32'(done), 1);
        checkOutput("wrap_error", 32'(error), 0);
        checkOutput("wrap_fffe", 32'(ram[16'hFFFE]), 32'hAA);
        checkOutput("wrap_ffff", 32'(ram[16'hFFFF]), 32'hBB);
        checkOutput("wrap_0000", 32'(ram[16'h0000]), 32'hCC);
        checkOutput("wrap_0001", 32'(ram[16'h0001]), 32'hDD);

        $display("[TB] reset mid-load");
        clearRams();
        @(posedge clk); #1;
        start = 1'b1; load_base = 16'h0000; load_len = LW'(16);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0, k = 0; i < 5 && k < 100; k++) begin
            in_valid = 1'b1;
            in_data = image[i];
            @(negedge clk);
            xf = in_ready;
            @(posedge clk); #1;
            if (xf) i++;
        end
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_cpu_reset", 32'(cpu_reset), 0);
        checkOutput("abort_in_ready", 32'(in_ready), 0);
        checkOutput("abort_mem_we", 32'(mem_we), 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) checkOutput("abort_mem", 32'(ram[i]), 32'(image[i]));
        checkOutput("abort_mem5", 32'(ram[5]), 0);

        $display("[TB] zero length then reload from run");
        words.delete();
        applyStimulus(16'h0040, 0, 1'b0, 1'b1, bc);
        @(negedge clk);
        checkOutput("zero_done", 32'(done), 1);
        checkOutput("zero_cpu_reset", 32'(cpu_reset), 1);
        words = '{8'h3C, 8'hC3};
        cpuSpam = 1'b1;
        applyStimulus(16'h0010, 2, 1'b0, 1'b1, bc);
        cpuSpam = 1'b0;
        checkOutput("reload_busy_cycles", 32'(bc), 32'(2 + CK));
        @(negedge clk);
        checkOutput("reload_done", 32'(done), 1);
        checkOutput("reload_mem10", 32'(ram[16'h0010]), 32'h3C);
        checkOutput("reload_mem11", 32'(ram[16'h0011]), 32'hC3);
        checkOutput("reload_cpu_blocked", 32'(ram[16'h1234]), 0);

`ifdef VCPU_LOADER_CHECKSUM_EN
        $display("[TB] checksum good and bad trailers");
        words = '{8'h01, 8'h02, 8'h03, 8'hFA};
        applyStimulus(16'h0200, 3, 1'b0, 1'b0, bc);
        @(negedge clk);
        checkOutput("ck_good_done", 32'(done), 1);
        checkOutput("ck_good_error", 32'(error), 0);
        checkOutput("ck_good_trailer", 32'(ram[16'h0203]), 0);
        words = '{8'h01, 8'h02, 8'h03, 8'hFB};
        applyStimulus(16'h0200, 3, 1'b0, 1'b0, bc);
        @(negedge clk);
        checkOutput("ck_bad_error", 32'(error), 1);
        checkOutput("ck_bad_cpu_reset", 32'(cpu_reset), 0);
        checkOutput("ck_bad_done", 32'(done), 0);
        checkOutput("ck_bad_trailer", 32'(ram[16'h0203]), 0);
        checkOutput("ck_bad_mem202", 32'(ram[16'h0202]), 32'h03);
        words = '{8'h01, 8'h02, 8'h03, 8'hFA};
        applyStimulus(16'h0200, 3, 1'b0, 1'b0, bc);
        @(negedge clk);
        checkOutput("ck_retry_error", 32'(error), 0);
        checkOutput("ck_retry_done", 32'(done), 1);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vcpu_mem_loader.md
Name: vcpu_mem_loader

Overview:
Program-image loader and memory-port owner for the vcpu. It streams a byte image over a valid/ready interface into memory starting at a programmable base address, holding the CPU in reset meanwhile. It then hands the single memory port to the CPU and releases CPU reset. This replaces bench-level manual loading and muxing with a synthesizable, parametrised block that sits between vcpu_cu and vcpu_mem.

Parameters:
ADDR_WIDTH, 16, memory address width; addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 8, memory/stream word width
LEN_WIDTH, ADDR_WIDTH+1, width of load length; allows a full 2^ADDR_WIDTH-word image

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a load (honoured in IDLE, RUN, ERROR)
load_base  in  ADDR_WIDTH  first write address, sampled on accepted start
load_len  in  LEN_WIDTH  payload word count, sampled on accepted start
in_valid  in  1  stream word valid
in_data  in  DATA_WIDTH  stream word
in_ready  out  1  loader accepts stream word
cpu_reset  out  1  active-low reset to vcpu_cu; 0 = CPU held
busy  out  1  load in progress
done  out  1  image loaded, CPU running
error  out  1  checksum failure (CHECKSUM_EN only; else constant 0)
cpu_mem_we  in  1  CPU write enable
cpu_mem_address  in  ADDR_WIDTH  CPU address
cpu_mem_data  in  DATA_WIDTH  CPU write data
cpu_mem_q  out  DATA_WIDTH  read data to CPU
mem_we  out  1  to memory
mem_address  out  ADDR_WIDTH  to memory
mem_data  out  DATA_WIDTH  to memory
mem_q  in  DATA_WIDTH  read data from memory

Behaviour:
- States: IDLE, LOAD, CKSUM (CHECKSUM_EN only), RUN, ERROR.
- Reset: state=IDLE, addr=0, count=0, cpu_reset=0, busy=0, done=0, error=0; in_ready=0, mem_we=0.
- Port ownership: in RUN, mem_* = cpu_mem_* combinationally. In all other states the loader drives mem_address=addr and mem_data=in_data, and mem_we=in_valid&&in_ready. CPU writes are dropped outside RUN. cpu_mem_q=mem_q always.
- IDLE: in_ready=0. start -> addr=load_base, count=load_len. If load_len!=0, go to LOAD; if load_len==0, go to RUN (or CKSUM if enabled).
- LOAD: in_ready=1 combinationally from state. Each transfer (in_valid&&in_ready) writes one word at the clock edge, then addr<=addr+1 (wraps silently at 2^ADDR_WIDTH) and count<=count-1. The transfer with count==1 goes to RUN (or CKSUM). in_valid gaps stall with no write. start is ignored in LOAD.
- RUN: registered outputs; cpu_reset=1 and done=1 from the first cycle in RUN (one cycle after the last write). in_ready=0. start -> cpu_reset=0 and done=0 next cycle, then the IDLE start rules apply (reload).
- busy=1 exactly in LOAD/CKSUM, registered alongside state.
- Asserting reset mid-load aborts immediately. Memory contents already written are kept.

Optional Feature:
Macro VCPU_LOADER_CHECKSUM_EN. When defined, the loader keeps a DATA_WIDTH running sum (mod 2^DATA_WIDTH) of the payload words, cleared on accepted start. After the payload it enters CKSUM with in_ready=1 and accepts one extra word, which is not written to memory (mem_we=0). If sum+word==0, go to RUN. Otherwise go to ERROR: error=1, cpu_reset=0, done=0, and start restarts the load (error cleared on start). When not defined, the CKSUM/ERROR states and the sum register are absent, error is tied 0, and LOAD goes directly to RUN.

Decomposition:
- Shared package vcpu_pkg: loader state enum, default widths (VCPU_ADDR_WIDTH=16, VCPU_DATA_WIDTH=8).
- One sub-module is natural: vcpu_mem_port_mux (combinational owner select for mem_*; reusable by a future debug port).
- FSM, counters and checksum stay in vcpu_mem_loader.

Test Plan:
- Image load: base=0x0000, len=16, stream bytes 50 11 01 22 52 50 05 10 50 12 80 11 77 56 F9 31 with in_valid steady. Expect MEM[0..15] to match, busy high for 16 cycles, then cpu_reset=1 and done=1 one cycle after the last write. CPU fetch at 0x0000 then returns 0x50.
- Backpressure gaps: same image with in_valid toggling 1,0,0,1. Expect identical memory, no writes on gap cycles, and the count reaches 0 only after 16 transfers.
- Wrap: base=0xFFFE, len=4, data AA BB CC DD. Expect MEM[FFFE]=AA, MEM[FFFF]=BB, MEM[0000]=CC, MEM[0001]=DD, no error.
- Zero length and reload: start with len=0 -> done=1 next cycle, no mem_we. While in RUN, pulse start with len=2 -> cpu_reset=0 next cycle, two words written, CPU re-released. CPU writes during the load never reach memory.
- Reset mid-load: assert reset after 5 of 16 words. Expect all outputs at reset values asynchronously and MEM[0..4] written.
- CHECKSUM_EN: payload 01 02 03 with trailer FA -> RUN. The same payload with trailer FB -> ERROR (error=1, cpu_reset=0), and the trailer word is never written to memory.
